sys_reset_seq: RTL
==================

SYS_RESET_SEQ -- requirements
Module: sys_reset_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, range 1..16: number of independent reset channels.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, range 1..65535: cycles channel 0 is held in reset.
REQ-003 SHALL have parameter STAGE_DELAY, default 8, range 1..65535: cycles between releases of consecutive channels.
REQ-004 SHALL have port clk  input  1: sole clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port stimuli_valid  input  1: a rising edge of this signal is a reset-request candidate.
REQ-007 SHALL have port do_reset  input  1: qualifies the stimuli_valid rising edge as a reset request.
REQ-008 SHALL have port ch_mask  input  NUM_CH: channels targeted by the request; sampled on the accepting edge.
REQ-009 SHALL have port resetn  output  NUM_CH: per-channel active-low reset, registered.
REQ-010 SHALL have port busy  output  1: high while any sequence is in progress.
REQ-011 SHALL have port reset_count  output  16: count of accepted requests, saturating.

Function
REQ-012 SHALL register stimuli_valid into stimuli_valid_d every cycle; edge = stimuli_valid & ~stimuli_valid_d.
REQ-013 SHALL accept a request on edge E0 iff edge & do_reset & (ch_mask != 0); otherwise the request is ignored with no state change.
REQ-014 SHALL use states IDLE, HOLD and RELEASE, with a hold counter, a stage counter and a stage index of $clog2-derived widths.
REQ-015 On acceptance, SHALL set active_mask = ch_mask | ~resetn, drive resetn[i]=0 for all i in active_mask, load hold counter = HOLD_CYCLES-1, and enter HOLD.
REQ-016 In HOLD, SHALL decrement the hold counter each cycle.
REQ-017 In HOLD, when the hold counter is 0, SHALL set resetn[0]=1 (no-op if already 1).
REQ-018 In HOLD, when the hold counter is 0, SHALL go to IDLE if NUM_CH=1.
REQ-019 In HOLD, when the hold counter is 0 and NUM_CH>1, SHALL set stage index=1, load stage counter = STAGE_DELAY-1, and enter RELEASE.
REQ-020 In RELEASE, SHALL decrement the stage counter each cycle.
REQ-021 In RELEASE, when the stage counter is 0, SHALL set resetn[stage]=1 and increment the stage index.
REQ-022 In RELEASE, when the stage counter is 0 and the stage index is NUM_CH-1, SHALL go to IDLE; otherwise SHALL reload the stage counter.
REQ-023 Timing: resetn[i] SHALL rise at clock edge E0 + HOLD_CYCLES + i*STAGE_DELAY; a channel not in active_mask SHALL stay high throughout.
REQ-024 busy SHALL be 1 in HOLD and RELEASE and 0 in IDLE, deasserting on the same edge the last channel is released.
REQ-025 An accepted request in HOLD or RELEASE SHALL restart the sequence per REQ-015; channels still low from the prior sequence SHALL stay low until released by the new timeline.
REQ-026 If an acceptance coincides with a release edge, acceptance SHALL win and the channel being released SHALL remain low if it is in the new active_mask.
REQ-027 reset_count SHALL increment by 1 per accepted request and hold at 16'hFFFF.

Reset
REQ-028 While reset=1, SHALL asynchronously force resetn=0 (all channels), busy=1, state HOLD, hold counter=HOLD_CYCLES-1, active_mask all ones, reset_count=0, stimuli_valid_d=1.
REQ-029 After reset deasserts, the power-on sequence SHALL run as if E0 were the last clock edge with reset high, releasing channel i at the (HOLD_CYCLES + i*STAGE_DELAY)-th rising edge after deassertion.
REQ-030 stimuli_valid held high through reset deassertion SHALL NOT generate a request.

Verification (defaults NUM_CH=4, HOLD_CYCLES=16, STAGE_DELAY=8)
REQ-031 Power-on: reset high 3 cycles, then low -> resetn=4'b0000; bits 0/1/2/3 rise at edges 16/24/32/40; busy falls at edge 40; reset_count=0.
REQ-032 Masked request: IDLE, do_reset=1, ch_mask=4'b0101, stimuli_valid 0->1 -> resetn[0] low 16 cycles, resetn[2] low 32 cycles, bits 1 and 3 stay 1; reset_count=1.
REQ-033 Rejection: do_reset=0 edge, ch_mask=0 edge, or stimuli_valid held high 50 cycles -> resetn=4'b1111, busy=0, reset_count unchanged.
REQ-034 Retrigger: accept mask 4'b0001 at E0, then mask 4'b0010 at E0+10 -> resetn=4'b1100 until bit 0 rises at E0+26 and bit 1 at E0+34; reset_count=2.
REQ-035 Async reset mid-RELEASE: assert reset between clock edges -> resetn=4'b0000 and busy=1 before the next edge; full power-on sequence reruns.
REQ-036 Collision: acceptance with mask 4'b0001 on the release edge of bit 0 -> resetn[0] stays 0 and rises 16 edges later.

Source files
------------

// File: rtl/sys_reset_seq_if.sv
// Reset-sequencer request/status bundle: request strobe, qualifier, channel mask, per-channel resets.
// Latency: none; wires only.
// Backpressure: none; a request is a rising edge of stimuli_valid and is never stalled.
interface sys_reset_seq_if #(
  parameter int NUM_CH = 4
) ();
  logic              stimuli_valid;
  logic              do_reset;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] resetn;
  logic              busy;
  logic [15:0]       reset_count;

  // Requester side
  modport master (
    output stimuli_valid,
    output do_reset,
    output ch_mask,
    input  resetn,
    input  busy,
    input  reset_count
  );

  // Sequencer side
  modport slave (
    input  stimuli_valid,
    input  do_reset,
    input  ch_mask,
    output resetn,
    output busy,
    output reset_count
  );
endinterface

// File: rtl/sys_reset_seq.sv
// Staged per-channel reset sequencer: holds selected channels low, then releases them one by one.
// Latency: channel i released HOLD_CYCLES + i*STAGE_DELAY edges after the accepting edge.
// Backpressure: none; a new accepted request simply restarts the timeline.
module sys_reset_seq #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8
) (
  input  logic           clk,
  input  logic           reset,
  sys_reset_seq_if.slave bus
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = $clog2(STAGE_DELAY + 1);
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] STAGE_LOAD = DW'(STAGE_DELAY - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_CH - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]        state;
  logic [HW-1:0]     hold_cnt;
  logic [DW-1:0]     stage_cnt;
  logic [SW-1:0]     stage_idx;
  logic [NUM_CH-1:0] resetn_q;
  logic [15:0]       count_q;
  logic              stimuli_valid_d;

  logic              edge_det;
  logic              accept;
  logic [NUM_CH-1:0] active_mask;

  // A request is a qualified rising edge; channels still low from an earlier
  // sequence are folded into the new mask so they follow the new timeline.
  assign edge_det    = bus.stimuli_valid & ~stimuli_valid_d;
  assign accept      = edge_det & bus.do_reset & (|bus.ch_mask);
  assign active_mask = bus.ch_mask | ~resetn_q;

  assign bus.resetn      = resetn_q;
  assign bus.busy        = (state != IDLE);
  assign bus.reset_count = count_q;

  // Edge-detect history; forced high in reset so a strobe held through reset is not a request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stimuli_valid_d <= 1'b1;
    else       stimuli_valid_d <= bus.stimuli_valid;
  end

  // Saturating count of accepted requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                count_q <= 16'd0;
    else if (accept && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
  end

  // Sequencer FSM; acceptance takes priority over any release on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HOLD;
      hold_cnt  <= HOLD_LOAD;
      stage_cnt <= '0;
      stage_idx <= '0;
      resetn_q  <= '0;
    end else if (accept) begin
      resetn_q <= resetn_q & ~active_mask;
      hold_cnt <= HOLD_LOAD;
      state    <= HOLD;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == '0) begin
            resetn_q[0] <= 1'b1;
            if (NUM_CH == 1) begin
              state <= IDLE;
            end else begin
              stage_idx <= SW'(1);
              stage_cnt <= STAGE_LOAD;
              state     <= RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        RELEASE: begin
          if (stage_cnt == '0) begin
            resetn_q[stage_idx] <= 1'b1;
            stage_idx           <= stage_idx + SW'(1);
            if (stage_idx == LAST_STAGE) state     <= IDLE;
            else                         stage_cnt <= STAGE_LOAD;
          end else begin
            stage_cnt <= stage_cnt - DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
